// File: rtl/arbitro_mux4.sv
// arbitro_mux4: round-robin arbiter driving a shared 4:1 data multiplexer.
// Four requesters compete for one data path. A two-state FSM (IDLE/GRANT)
// hands out a one-hot grant, holds it while the owner keeps requesting, and
// always inserts one IDLE cycle between owners. The selected word and a
// valid flag come out one cycle after the grant.
//
// Optional feature: define ARB_BURST_LIMIT_EN to cap each ownership at
// MAX_BURST consecutive grant cycles. In the default build no counter exists
// and MAX_BURST only goes through the range check.
module arbitro_mux4 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last;        // most recent owner; lowest priority next round
    logic [1:0] winner;      // round-robin pick from the current requests
    logic       burst_done;  // owner has used up its allowed burst

    // The burst counter is 4 bits wide, so the cap must fit in 1..15.
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("arbitro_mux4: MAX_BURST must be in 1..15");
    end

    // Scan requesters in the order last+1, last+2, last+3, last+4 (mod 4)
    // and return the first one found. The scan runs backwards so the
    // nearest match is the one that is kept.
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        // NOTE: every variable written here gets a value before any branch
        // can skip it; otherwise a combinational block infers a latch.
        pick = p;
        idx  = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Pick the next owner from the current requests and the pointer.
    always_comb begin
        winner = pick_winner(req, last);
    end

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [3:0] burst_cnt;

    // Count grant cycles; held at zero in IDLE so each new ownership starts at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (state == GRANT) begin
            burst_cnt <= burst_cnt + 4'd1;
        end else begin
            burst_cnt <= '0;
        end
    end

    // The grant cycle whose count reads MAX_BURST-1 is the owner's last one.
    assign burst_done = (burst_cnt == BURST_LAST);
`else
    assign burst_done = 1'b0;
`endif

    // Arbitration FSM: grants, mux select and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: reset is asynchronous and active-high, so it sits in the
        // sensitivity list and clears the outputs without waiting for a clock.
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= 2'd3;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register sees the values from before this edge.
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << winner;
                        sel   <= winner;
                        last  <= winner;
                    end
                end
                GRANT: begin
                    // Only the owner's own request matters here; other
                    // requesters wait until the owner lets go.
                    if (!req[sel] || burst_done) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Data path register: mux the word picked by sel and flag grant cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y     <= '0;
            valid <= 1'b0;
        end else begin
            case (sel)
                2'd0:    y <= d0;
                2'd1:    y <= d1;
                2'd2:    y <= d2;
                default: y <= d3;
            endcase
            valid <= (state == GRANT);
        end
    end

endmodule

// File: tb/tb_arbitro_mux4.sv
// tb_arbitro_mux4: directed vectors for arbitro_mux4. A table of
// {req, d0, expected gnt/sel/y/valid} rows covers rotation, idle hold,
// the pointer and no-preemption. Hand-written sequences cover the burst
// limit (expectations follow ARB_BURST_LIMIT_EN) and asynchronous reset
// in the middle of a grant.
module tb_arbitro_mux4;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       req   = '0;
    logic [WIDTH-1:0] d0    = 8'hA0;
    logic [WIDTH-1:0] d1    = 8'hB1;
    logic [WIDTH-1:0] d2    = 8'hC2;
    logic [WIDTH-1:0] d3    = 8'hD3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic             valid;

    int n_vec = 0;
    int n_err = 0;

    arbitro_mux4 #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]       req;
        logic [WIDTH-1:0] d0;
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic [WIDTH-1:0] y;
        logic             valid;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] burst_exp[11];

        // Rotation with every owner releasing after 2 cycles, then idle hold,
        // y updating while invalid, pointer order and no preemption.
        vecs[0]  = '{4'b1111, 8'hA0, 4'b0001, 2'd0, 8'hA0, 1'b0};
        vecs[1]  = '{4'b1111, 8'hA0, 4'b0001, 2'd0, 8'hA0, 1'b1};
        vecs[2]  = '{4'b1110, 8'hA0, 4'b0000, 2'd0, 8'hA0, 1'b1};
        vecs[3]  = '{4'b1111, 8'hA0, 4'b0010, 2'd1, 8'hA0, 1'b0};
        vecs[4]  = '{4'b1111, 8'hA0, 4'b0010, 2'd1, 8'hB1, 1'b1};
        vecs[5]  = '{4'b1101, 8'hA0, 4'b0000, 2'd1, 8'hB1, 1'b1};
        vecs[6]  = '{4'b1111, 8'hA0, 4'b0100, 2'd2, 8'hB1, 1'b0};
        vecs[7]  = '{4'b1111, 8'hA0, 4'b0100, 2'd2, 8'hC2, 1'b1};
        vecs[8]  = '{4'b1011, 8'hA0, 4'b0000, 2'd2, 8'hC2, 1'b1};
        vecs[9]  = '{4'b1111, 8'hA0, 4'b1000, 2'd3, 8'hC2, 1'b0};
        vecs[10] = '{4'b1111, 8'hA0, 4'b1000, 2'd3, 8'hD3, 1'b1};
        vecs[11] = '{4'b0111, 8'hA0, 4'b0000, 2'd3, 8'hD3, 1'b1};
        vecs[12] = '{4'b1111, 8'hA0, 4'b0001, 2'd0, 8'hD3, 1'b0};
        vecs[13] = '{4'b1111, 8'hA0, 4'b0001, 2'd0, 8'hA0, 1'b1};
        vecs[14] = '{4'b0000, 8'hA0, 4'b0000, 2'd0, 8'hA0, 1'b1};
        vecs[15] = '{4'b0000, 8'hA0, 4'b0000, 2'd0, 8'hA0, 1'b0};
        vecs[16] = '{4'b0000, 8'h55, 4'b0000, 2'd0, 8'h55, 1'b0};
        vecs[17] = '{4'b0100, 8'hA0, 4'b0100, 2'd2, 8'hA0, 1'b0};
        vecs[18] = '{4'b0101, 8'hA0, 4'b0100, 2'd2, 8'hC2, 1'b1};
        vecs[19] = '{4'b0001, 8'hA0, 4'b0000, 2'd2, 8'hC2, 1'b1};
        vecs[20] = '{4'b0001, 8'hA0, 4'b0001, 2'd0, 8'hC2, 1'b0};
        vecs[21] = '{4'b0000, 8'hA0, 4'b0000, 2'd0, 8'hA0, 1'b1};
        vecs[22] = '{4'b1001, 8'hA0, 4'b1000, 2'd3, 8'hA0, 1'b0};
        vecs[23] = '{4'b0000, 8'hA0, 4'b0000, 2'd3, 8'hD3, 1'b1};

`ifdef ARB_BURST_LIMIT_EN
        burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                      4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                      4'b0001};
`else
        burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                      4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                      4'b0001};
`endif

        // Reset state.
        do_reset();
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_y", 32'(y), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 24; i++) begin
            req = vecs[i].req;
            d0  = vecs[i].d0;
            tick();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
        end

        // Burst limit with requesters 0 and 1 both holding high.
        req = '0;
        d0  = 8'hA0;
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("burst%0d_gnt", i), 32'(gnt), 32'(burst_exp[i]));
        end

        // Asynchronous reset in the middle of a grant to requester 1.
        req = '0;
        do_reset();
        req = 4'b0010;
        tick();
        check("midrst_pre_gnt", 32'(gnt), 32'h2);
        tick();
        check("midrst_pre_valid", 32'(valid), 32'h1);
        check("midrst_pre_y", 32'(y), 32'hB1);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_sel", 32'(sel), 32'h0);
        check("midrst_y", 32'(y), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        check("midrst_post_gnt", 32'(gnt), 32'h2);
        check("midrst_post_sel", 32'(sel), 32'h1);
        tick();
        check("midrst_post_valid", 32'(valid), 32'h1);
        check("midrst_post_y", 32'(y), 32'hB1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
